// File: rtl/accel_ctrl_pkg.sv
// Shared definitions for the accelerator layer/stage sequencer.
// State encodings are exported as plain localparams so datapath blocks and
// benches can decode the state bus without pulling in the enum type.
package accel_ctrl_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ISSUE = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_NEXT  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;
  localparam logic [2:0] ST_ERR   = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_ISSUE = ST_ISSUE,
    S_WAIT  = ST_WAIT,
    S_NEXT  = ST_NEXT,
    S_DONE  = ST_DONE,
    S_ERR   = ST_ERR
  } ctrl_state_e;

  // Width of an index over n items; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/stage_watchdog.sv
// Per-stage watchdog: counts cycles while enabled, saturates at all-ones,
// and flags expiry on the cycle in which the count reaches the limit.
module stage_watchdog #(
  parameter int TIMEOUT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 enable,
  input  logic [TIMEOUT_W-1:0] limit,
  output logic                 expired
);

  logic [TIMEOUT_W-1:0] count_q;
  logic [TIMEOUT_W:0]   count_inc;

  // Saturating cycle counter, zeroed by reset or by the clear strobe.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count_q <= '0;
    end else if (enable && (count_q != '1)) begin
      count_q <= count_q + 1'b1;
    end
  end

  // The current cycle is counted as well, so the N-th enabled cycle after a
  // clear expires a limit of N. A zero limit disables the watchdog.
  always_comb begin
    count_inc = {1'b0, count_q} + {{TIMEOUT_W{1'b0}}, 1'b1};
    expired   = enable && (limit != '0) && (count_inc >= {1'b0, limit});
  end

endmodule

// File: rtl/accel_state_control.sv
// Layer/stage sequencer: for each layer, launches every pipeline stage in
// turn and waits for its completion pulse, with a per-stage watchdog,
// abort, and an error state that is left by a fresh start.
module accel_state_control
  import accel_ctrl_pkg::*;
#(
  parameter int NUM_STAGES = 3,
  parameter int LAYER_W    = 4,
  parameter int TIMEOUT_W  = 16,
  localparam int SIDX_W    = idx_width(NUM_STAGES)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [LAYER_W-1:0]    num_layers,
  input  logic [TIMEOUT_W-1:0]  timeout_limit,
  input  logic [NUM_STAGES-1:0] stage_finish,
  output logic [NUM_STAGES-1:0] stage_start,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [2:0]            state,
  output logic [SIDX_W-1:0]     stage_idx,
  output logic [LAYER_W-1:0]    layer_idx
);

  localparam logic [SIDX_W-1:0] LAST_STAGE = SIDX_W'(NUM_STAGES - 1);

  // rst_n is active-high despite its name.
  logic rst;
  assign rst = rst_n;

  ctrl_state_e          state_q, state_d;
  logic [SIDX_W-1:0]    stage_q, stage_d;
  logic [LAYER_W-1:0]   layer_q, layer_d;
  logic [LAYER_W-1:0]   layers_q, layers_d;
  logic [NUM_STAGES-1:0] stage_onehot;
  logic                 finish_cur;
  logic                 wd_clear;
  logic                 wd_enable;
  logic                 wd_expired;

  // One-hot of the current stage; only its own finish bit is honoured.
  always_comb begin
    stage_onehot = NUM_STAGES'(1) << stage_q;
    finish_cur   = |(stage_finish & stage_onehot);
    wd_clear     = (state_q == S_ISSUE);
    wd_enable    = (state_q == S_WAIT);
  end

  stage_watchdog #(
    .TIMEOUT_W (TIMEOUT_W)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (wd_clear),
    .enable  (wd_enable),
    .limit   (timeout_limit),
    .expired (wd_expired)
  );

  // State and counter registers; reset returns everything to idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      stage_q  <= '0;
      layer_q  <= '0;
      layers_q <= '0;
    end else begin
      state_q  <= state_d;
      stage_q  <= stage_d;
      layer_q  <= layer_d;
      layers_q <= layers_d;
    end
  end

  // Next-state and counter update; abort overrides every other event.
  always_comb begin
    state_d  = state_q;
    stage_d  = stage_q;
    layer_d  = layer_q;
    layers_d = layers_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          stage_d  = '0;
          layer_d  = '0;
          layers_d = num_layers;
          state_d  = (num_layers != '0) ? S_ISSUE : S_DONE;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A finish in the expiry cycle still counts as success.
        if (finish_cur) begin
          state_d = S_NEXT;
        end else if (wd_expired) begin
          state_d = S_ERR;
        end
      end
      S_NEXT: begin
        if (stage_q < LAST_STAGE) begin
          stage_d = stage_q + 1'b1;
          state_d = S_ISSUE;
        end else begin
          stage_d = '0;
          if (layer_q == (layers_q - 1'b1)) begin
            state_d = S_DONE;
          end else begin
            layer_d = layer_q + 1'b1;
            state_d = S_ISSUE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      S_ERR: begin
        if (start) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
    end
  end

  // Outputs decode only from registered state and counters.
  always_comb begin
    stage_start = (state_q == S_ISSUE) ? stage_onehot : '0;
    busy        = (state_q != S_IDLE);
    done        = (state_q == S_DONE);
    error       = (state_q == S_ERR);
    state       = state_q;
    stage_idx   = stage_q;
    layer_idx   = layer_q;
  end

endmodule

// File: tb/tb_accel_state_control.sv
// Directed bench for accel_state_control with NUM_STAGES=3, LAYER_W=4.
module tb_accel_state_control;

  localparam logic [2:0] E_IDLE  = 3'd0;
  localparam logic [2:0] E_ISSUE = 3'd1;
  localparam logic [2:0] E_WAIT  = 3'd2;
  localparam logic [2:0] E_NEXT  = 3'd3;
  localparam logic [2:0] E_DONE  = 3'd4;
  localparam logic [2:0] E_ERR   = 3'd5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [3:0]  num_layers = 4'd0;
  logic [15:0] timeout_limit = 16'd0;
  logic [2:0]  stage_finish = 3'b000;
  logic [2:0]  stage_start;
  logic        busy;
  logic        done;
  logic        error;
  logic [2:0]  state;
  logic [1:0]  stage_idx;
  logic [3:0]  layer_idx;

  int errors = 0;
  int checks = 0;

  accel_state_control #(
    .NUM_STAGES (3),
    .LAYER_W    (4),
    .TIMEOUT_W  (16)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .abort         (abort),
    .num_layers    (num_layers),
    .timeout_limit (timeout_limit),
    .stage_finish  (stage_finish),
    .stage_start   (stage_start),
    .busy          (busy),
    .done          (done),
    .error         (error),
    .state         (state),
    .stage_idx     (stage_idx),
    .layer_idx     (layer_idx)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "bench time limit");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue -> finish in first WAIT cycle -> next; leaves bench in the cycle after NEXT.
  task automatic run_stage(input int s);
    step();
    stage_finish = 3'b001 << s;
    step();
    stage_finish = 3'b000;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    step();
    step();
    rst_n = 1'b0;
    checks++; if (state !== E_IDLE) begin errors++; $display("FAIL reset_state: got %0d want %0d", state, E_IDLE); end
    checks++; if ({busy, done, error} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {busy, done, error}); end
    checks++; if (stage_start !== 3'b000) begin errors++; $display("FAIL reset_stage_start: got %b want 000", stage_start); end
    checks++; if ({stage_idx, layer_idx} !== 6'd0) begin errors++; $display("FAIL reset_idx: got %0d/%0d want 0/0", stage_idx, layer_idx); end
  endtask

  task automatic test_two_layers();
    logic [2:0] exp_ss;
    int done_seen;
    done_seen = 0;
    timeout_limit = 16'd0;
    num_layers = 4'd2;
    start = 1'b1;
    step();
    start = 1'b0;
    num_layers = 4'd7;
    for (int i = 0; i < 6; i++) begin
      exp_ss = 3'b001 << (i % 3);
      checks++; if (stage_start !== exp_ss) begin errors++; $display("FAIL seq_stage_start[%0d]: got %b want %b", i, stage_start, exp_ss); end
      checks++; if (layer_idx !== 4'(i / 3)) begin errors++; $display("FAIL seq_layer[%0d]: got %0d want %0d", i, layer_idx, i / 3); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL seq_busy[%0d]: got %b want 1", i, busy); end
      step();
      checks++; if (stage_start !== 3'b000) begin errors++; $display("FAIL seq_start_pulse[%0d]: got %b want 000", i, stage_start); end
      step();
      stage_finish = exp_ss;
      step();
      stage_finish = 3'b000;
      checks++; if (state !== E_NEXT) begin errors++; $display("FAIL seq_next[%0d]: got %0d want %0d", i, state, E_NEXT); end
      if (done === 1'b1) done_seen++;
      step();
      if (done === 1'b1) done_seen++;
    end
    checks++; if (state !== E_DONE) begin errors++; $display("FAIL seq_done_state: got %0d want %0d", state, E_DONE); end
    checks++; if ({stage_idx, layer_idx} !== {2'd0, 4'd1}) begin errors++; $display("FAIL seq_final_idx: got %0d/%0d want 0/1", stage_idx, layer_idx); end
    step();
    checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL seq_idle_after: got busy=%b done=%b want 0 0", busy, done); end
    checks++; if (done_seen !== 1) begin errors++; $display("FAIL seq_done_count: got %0d want 1", done_seen); end
    checks++; if (layer_idx !== 4'd1) begin errors++; $display("FAIL seq_layer_hold: got %0d want 1", layer_idx); end
  endtask

  task automatic test_zero_layers();
    num_layers = 4'd0;
    start = 1'b1;
    step();
    start = 1'b0;
    checks++; if ({state, done, busy} !== {E_DONE, 1'b1, 1'b1}) begin errors++; $display("FAIL zero_done: got state=%0d done=%b busy=%b want 4 1 1", state, done, busy); end
    checks++; if (stage_start !== 3'b000) begin errors++; $display("FAIL zero_no_start: got %b want 000", stage_start); end
    step();
    checks++; if ({state, done, stage_start} !== {E_IDLE, 1'b0, 3'b000}) begin errors++; $display("FAIL zero_idle: got state=%0d done=%b ss=%b want 0 0 000", state, done, stage_start); end
  endtask

  task automatic test_timeout();
    timeout_limit = 16'd5;
    num_layers = 4'd1;
    start = 1'b1;
    step();
    start = 1'b0;
    run_stage(0);
    checks++; if ({state, stage_idx} !== {E_ISSUE, 2'd1}) begin errors++; $display("FAIL to_stage1: got state=%0d idx=%0d want 1 1", state, stage_idx); end
    for (int i = 0; i < 5; i++) step();
    checks++; if ({state, error} !== {E_WAIT, 1'b0}) begin errors++; $display("FAIL to_wait5: got state=%0d err=%b want 2 0", state, error); end
    step();
    checks++; if ({state, error, busy} !== {E_ERR, 1'b1, 1'b1}) begin errors++; $display("FAIL to_err: got state=%0d err=%b busy=%b want 5 1 1", state, error, busy); end
    checks++; if ({stage_idx, layer_idx} !== {2'd1, 4'd0}) begin errors++; $display("FAIL to_frozen_idx: got %0d/%0d want 1/0", stage_idx, layer_idx); end
    step();
    checks++; if (state !== E_ERR) begin errors++; $display("FAIL to_err_hold: got %0d want 5", state); end
    start = 1'b1;
    step();
    start = 1'b0;
    checks++; if ({state, error, busy} !== {E_IDLE, 1'b0, 1'b0}) begin errors++; $display("FAIL to_clear: got state=%0d err=%b busy=%b want 0 0 0", state, error, busy); end
    step();
    checks++; if (stage_start !== 3'b000) begin errors++; $display("FAIL to_no_new_run: got %b want 000", stage_start); end
  endtask

  task automatic test_coincide();
    timeout_limit = 16'd4;
    num_layers = 4'd1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) step();
    stage_finish = 3'b001;
    step();
    stage_finish = 3'b000;
    checks++; if ({state, error} !== {E_NEXT, 1'b0}) begin errors++; $display("FAIL coincide_next: got state=%0d err=%b want 3 0", state, error); end
    abort = 1'b1;
    step();
    abort = 1'b0;
    timeout_limit = 16'd0;
  endtask

  task automatic test_abort();
    timeout_limit = 16'd0;
    num_layers = 4'd3;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    stage_finish = 3'b110;
    start = 1'b1;
    step();
    stage_finish = 3'b000;
    start = 1'b0;
    checks++; if ({state, stage_idx} !== {E_WAIT, 2'd0}) begin errors++; $display("FAIL abort_ignore: got state=%0d idx=%0d want 2 0", state, stage_idx); end
    stage_finish = 3'b001;
    step();
    stage_finish = 3'b000;
    step();
    run_stage(1);
    run_stage(2);
    checks++; if ({state, layer_idx, stage_idx} !== {E_ISSUE, 4'd1, 2'd0}) begin errors++; $display("FAIL abort_layer1: got state=%0d L=%0d S=%0d want 1 1 0", state, layer_idx, stage_idx); end
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    checks++; if ({state, done, error, busy} !== {E_IDLE, 3'b000}) begin errors++; $display("FAIL abort_idle: got state=%0d d=%b e=%b b=%b want 0 0 0 0", state, done, error, busy); end
    step();
    checks++; if ({done, stage_start} !== 4'b0000) begin errors++; $display("FAIL abort_quiet: got done=%b ss=%b want 0 000", done, stage_start); end
  endtask

  task automatic test_reset_midrun();
    num_layers = 4'd2;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    rst_n = 1'b1;
    abort = 1'b1;
    step();
    rst_n = 1'b0;
    abort = 1'b0;
    checks++; if ({state, busy, done, error, stage_start} !== {E_IDLE, 3'b000, 3'b000}) begin errors++; $display("FAIL rst_mid_out: got state=%0d b=%b d=%b e=%b ss=%b want all 0", state, busy, done, error, stage_start); end
    num_layers = 4'd1;
    start = 1'b1;
    step();
    start = 1'b0;
    checks++; if (stage_start !== 3'b001) begin errors++; $display("FAIL rst_fresh_start: got %b want 001", stage_start); end
    run_stage(0);
    run_stage(1);
    run_stage(2);
    checks++; if ({state, done} !== {E_DONE, 1'b1}) begin errors++; $display("FAIL rst_fresh_done: got state=%0d done=%b want 4 1", state, done); end
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_fresh_idle: got busy=%b want 0", busy); end
  endtask

  initial begin
    test_reset();
    test_two_layers();
    test_zero_layers();
    test_timeout();
    test_coincide();
    test_abort();
    test_reset_midrun();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
